// File: rtl/writeback_unit_if.sv
// Memory-stage to writeback handshake: W_pre result, dbus response and the stall/req_block
// back-pressure returned to the memory stage.
interface writeback_unit_if;
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  regw;
        logic [31:0] val_a;
        logic        rm;
        logic        wen;
    } w_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    w_t         W_pre;
    logic       mem_valid;
    logic       mem_is_load;
    dbus_resp_t dresp;
    logic       req_block;
    logic       stall_m;

    modport master (
        output W_pre, mem_valid, mem_is_load, dresp,
        input  req_block, stall_m
    );

    modport slave (
        input  W_pre, mem_valid, mem_is_load, dresp,
        output req_block, stall_m
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: tracks the dbus request of the memory stage, latches the W register and drives
// the register-file write, commit and stall outputs. Define WB_BYPASS_EN to enable the bypass.
module writeback_unit #(
    parameter int unsigned StallCntWidth = 32
) (
    input  logic                clk,
    input  logic                resetn,
    writeback_unit_if.slave     wb,
    output logic                rf_wen,
    output logic [4:0]          rf_waddr,
    output logic [31:0]         rf_wdata,
    output logic                commit_valid,
    output logic [31:0]         commit_pc,
    output logic                fwd_valid,
    output logic [4:0]          fwd_reg,
    output logic [31:0]         fwd_data,
    output logic [31:0]         stall_cycles
);
    typedef enum logic [1:0] {StIdle, StWaitAddr, StWaitData} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  regw;
        logic [31:0] val_a;
        logic        wen;
    } wreg_t;

    typedef logic [StallCntWidth-1:0] cnt_t;

    state_e state_q, state_d;
    wreg_t  w_q, w_d;
    cnt_t   cnt_q, cnt_d;
    logic   stall;
    logic   complete;
    logic   stall_m_int;
    logic   unused_rm;

    assign unused_rm = wb.W_pre.rm;

    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
            StIdle: begin
                if (wb.mem_valid) begin
                    if (wb.dresp.addr_ok && wb.dresp.data_ok) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = wb.dresp.addr_ok ? StWaitData : StWaitAddr;
                    end
                end
            end
            StWaitAddr: begin
                if (wb.dresp.addr_ok && wb.dresp.data_ok) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end else begin
                    stall = 1'b1;
                    if (wb.dresp.addr_ok) begin
                        state_d = StWaitData;
                    end
                end
            end
            StWaitData: begin
                // A stray addr_ok here has no meaning; only data_ok is looked at.
                if (wb.dresp.data_ok) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        w_d = '0;
        if (!stall) begin
            w_d.pc    = wb.W_pre.pc;
            w_d.regw  = wb.W_pre.regw;
            w_d.val_a = (complete && wb.mem_is_load) ? wb.dresp.data : wb.W_pre.val_a;
            w_d.wen   = wb.W_pre.wen;
        end
    end

    // Combinational outputs are gated so that every output is zero while reset is held.
    assign stall_m_int  = stall & resetn;
    assign wb.stall_m   = stall_m_int;
    // The accepted request stays visible for the whole WAIT_DATA residency, data_ok cycle included.
    assign wb.req_block = (state_q == StWaitData) & resetn;

    always_comb begin
        cnt_d = cnt_q;
        if (stall_m_int && (cnt_q != '1)) begin
            cnt_d = cnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            w_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rf_wen       = w_q.wen & (w_q.regw != 5'd0);
    assign rf_waddr     = w_q.regw;
    assign rf_wdata     = w_q.val_a;
    assign commit_valid = (w_q.pc != 32'd0);
    assign commit_pc    = w_q.pc;
    assign stall_cycles = 32'(cnt_q);

`ifdef WB_BYPASS_EN
    assign fwd_valid = rf_wen;
    assign fwd_reg   = rf_waddr;
    assign fwd_data  = rf_wdata;
`else
    assign fwd_valid = 1'b0;
    assign fwd_reg   = 5'd0;
    assign fwd_data  = 32'd0;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: table of single-cycle retirements, hand-written multi-cycle dbus
// sequences, and a narrow-counter instance held in permanent stall to reach saturation.
module tb_writeback_unit;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    writeback_unit_if wb_a ();
    writeback_unit_if wb_s ();

    logic        rf_wen, commit_valid, fwd_valid;
    logic [4:0]  rf_waddr, fwd_reg;
    logic [31:0] rf_wdata, commit_pc, fwd_data, stall_cycles;

    logic        s_rf_wen, s_commit_valid, s_fwd_valid;
    logic [4:0]  s_rf_waddr, s_fwd_reg;
    logic [31:0] s_rf_wdata, s_commit_pc, s_fwd_data, s_stall_cycles;

    writeback_unit #(.StallCntWidth(32)) dut (
        .clk(clk), .resetn(resetn), .wb(wb_a),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
        .stall_cycles(stall_cycles)
    );

    writeback_unit #(.StallCntWidth(2)) dut_sat (
        .clk(clk), .resetn(resetn), .wb(wb_s),
        .rf_wen(s_rf_wen), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
        .commit_valid(s_commit_valid), .commit_pc(s_commit_pc),
        .fwd_valid(s_fwd_valid), .fwd_reg(s_fwd_reg), .fwd_data(s_fwd_data),
        .stall_cycles(s_stall_cycles)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        wen;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  regw;
        logic [31:0] val_a;
        logic        wen;
        logic        mv;
        logic        ld;
        logic        aok;
        logic        dok;
        logic [31:0] data;
        logic        exp_wen;
        logic [31:0] exp_wdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] regw, input logic [31:0] val_a,
                         input logic wen, input logic mv, input logic ld, input logic aok,
                         input logic dok, input logic [31:0] data);
        wb_a.W_pre.pc        = pc;
        wb_a.W_pre.regw      = regw;
        wb_a.W_pre.val_a     = val_a;
        wb_a.W_pre.rm        = ld;
        wb_a.W_pre.wen       = wen;
        wb_a.mem_valid       = mv;
        wb_a.mem_is_load     = ld;
        wb_a.dresp.addr_ok   = aok;
        wb_a.dresp.data_ok   = dok;
        wb_a.dresp.data      = data;
    endtask

    task automatic push(input logic [31:0] pc, input logic [4:0] waddr, input logic [31:0] wdata,
                        input logic wen);
        exp_t e;
        e.pc    = pc;
        e.waddr = waddr;
        e.wdata = wdata;
        e.wen   = wen;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Retirement monitor: every commit must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (resetn && commit_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL commit_unexpected: got pc 0x%08h, expected no commit", commit_pc);
            end else begin
                e = sb.pop_front();
                check("commit_pc", commit_pc, e.pc);
                check("rf_wen", 32'(rf_wen), 32'(e.wen));
                check("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
                check("rf_wdata", rf_wdata, e.wdata);
`ifdef WB_BYPASS_EN
                check("fwd_valid", 32'(fwd_valid), 32'(e.wen));
                check("fwd_reg", 32'(fwd_reg), 32'(e.waddr));
                check("fwd_data", fwd_data, e.wdata);
`else
                check("fwd_valid_off", 32'(fwd_valid), 32'd0);
                check("fwd_reg_off", 32'(fwd_reg), 32'd0);
                check("fwd_data_off", fwd_data, 32'd0);
`endif
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        vec_t vecs[9];
        vecs[0] = '{32'h8000_0000, 5'd5,  32'h0000_1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    32'h0, 1'b1, 32'h0000_1234};
        vecs[1] = '{32'h8000_0004, 5'd7,  32'h0000_0777, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    32'h0, 1'b1, 32'h0000_0777};
        vecs[2] = '{32'h8000_0008, 5'd0,  32'h0000_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    32'h0, 1'b0, 32'h0000_FFFF};
        vecs[3] = '{32'h8000_000C, 5'd4,  32'h0000_9999, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    32'h0, 1'b0, 32'h0000_9999};
        vecs[4] = '{32'h8000_0010, 5'd6,  32'h0000_1000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                    32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
        vecs[5] = '{32'h8000_0014, 5'd2,  32'h0000_2222, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                    32'h0000_0BAD, 1'b0, 32'h0000_2222};
        vecs[6] = '{32'h0000_0000, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    32'h0, 1'b0, 32'h0};
        vecs[7] = '{32'h8000_0018, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    32'h0, 1'b1, 32'hFFFF_FFFF};
        vecs[8] = '{32'h8000_0020, 5'd8,  32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                    32'h1234_5678, 1'b1, 32'h0000_0000};

        resetn = 1'b0;
        wb_s.W_pre       = '0;
        wb_s.mem_valid   = 1'b1;
        wb_s.mem_is_load = 1'b0;
        wb_s.dresp       = '0;
        drive(32'h8000_00F0, 5'd1, 32'h1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        #12;
        check("rst_stall_m", 32'(wb_a.stall_m), 32'd0);
        check("rst_req_block", 32'(wb_a.req_block), 32'd0);
        check("rst_rf_wen", 32'(rf_wen), 32'd0);
        check("rst_commit_valid", 32'(commit_valid), 32'd0);
        check("rst_stall_cycles", stall_cycles, 32'd0);
        check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        check("rst_sat_stall_m", 32'(wb_s.stall_m), 32'd0);

        next_cycle();
        resetn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].pc, vecs[i].regw, vecs[i].val_a, vecs[i].wen, vecs[i].mv, vecs[i].ld,
                  vecs[i].aok, vecs[i].dok, vecs[i].data);
            if (vecs[i].pc != 32'd0) begin
                push(vecs[i].pc, vecs[i].regw, vecs[i].exp_wdata, vecs[i].exp_wen);
            end
            @(negedge clk);
            check("tbl_stall_m", 32'(wb_a.stall_m), 32'd0);
            check("tbl_req_block", 32'(wb_a.req_block), 32'd0);
            check("sat_ramp", s_stall_cycles, (i < 3) ? 32'(i) : 32'd3);
            next_cycle();
        end
        drive(32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("tbl_stall_cycles", stall_cycles, 32'd0);
        next_cycle();

        // Load: addr_ok in cycle 0, data in cycle 2 alongside a stray addr_ok.
        drive(32'h8000_0100, 5'd3, 32'h0000_AAAA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        push(32'h8000_0100, 5'd3, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        check("ld_c0_stall_m", 32'(wb_a.stall_m), 32'd1);
        check("ld_c0_req_block", 32'(wb_a.req_block), 32'd0);
        next_cycle();
        drive(32'h8000_0100, 5'd3, 32'h0000_AAAA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("ld_c1_stall_m", 32'(wb_a.stall_m), 32'd1);
        check("ld_c1_req_block", 32'(wb_a.req_block), 32'd1);
        next_cycle();
        drive(32'h8000_0100, 5'd3, 32'h0000_AAAA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        check("ld_c2_stall_m", 32'(wb_a.stall_m), 32'd0);
        next_cycle();
        drive(32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("ld_c3_commit", 32'(commit_valid), 32'd1);
        check("ld_c3_rf_wen", 32'(rf_wen), 32'd1);
        check("ld_stall_cycles", stall_cycles, 32'd2);
        next_cycle();

        // Store: addr_ok withheld for 3 cycles, then addr_ok and data_ok together.
        push(32'h8000_0200, 5'd9, 32'h0000_0055, 1'b0);
        for (int c = 0; c < 3; c++) begin
            drive(32'h8000_0200, 5'd9, 32'h0000_0055, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            check("st_wait_stall_m", 32'(wb_a.stall_m), 32'd1);
            check("st_wait_req_block", 32'(wb_a.req_block), 32'd0);
            next_cycle();
        end
        drive(32'h8000_0200, 5'd9, 32'h0000_0055, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_7777);
        @(negedge clk);
        check("st_done_stall_m", 32'(wb_a.stall_m), 32'd0);
        check("st_done_req_block", 32'(wb_a.req_block), 32'd0);
        next_cycle();
        drive(32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("st_commit", 32'(commit_valid), 32'd1);
        check("st_rf_wen", 32'(rf_wen), 32'd0);
        check("st_stall_cycles", stall_cycles, 32'd5);
        next_cycle();

        // Reset pulse while waiting for load data, then a late data_ok with no request.
        drive(32'h8000_0300, 5'd10, 32'h0000_0044, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("rst_mid_c0_stall_m", 32'(wb_a.stall_m), 32'd1);
        next_cycle();
        drive(32'h8000_0300, 5'd10, 32'h0000_0044, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("rst_mid_c1_req_block", 32'(wb_a.req_block), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_mid_stall_m", 32'(wb_a.stall_m), 32'd0);
        check("rst_mid_req_block", 32'(wb_a.req_block), 32'd0);
        check("rst_mid_stall_cycles", stall_cycles, 32'd0);
        next_cycle();
        resetn = 1'b1;
        drive(32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1111);
        @(negedge clk);
        check("late_dok_stall_m", 32'(wb_a.stall_m), 32'd0);
        check("late_dok_req_block", 32'(wb_a.req_block), 32'd0);
        next_cycle();
        drive(32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("late_dok_rf_wen", 32'(rf_wen), 32'd0);
        check("late_dok_commit", 32'(commit_valid), 32'd0);
        check("late_dok_stall_cycles", stall_cycles, 32'd0);
        for (int c = 0; c < 6; c++) begin
            next_cycle();
        end
        @(negedge clk);
        check("sat_stall_cycles", s_stall_cycles, 32'd3);
        check("sat_stall_m", 32'(wb_s.stall_m), 32'd1);
        check("sat_req_block", 32'(wb_s.req_block), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
